y_rr_mux_reg: RTL and testbench
===============================

// Module: y_rr_mux_reg
// PURPOSE
//   Parametrised NCH-channel, SIZE-bit registered multiplexer with valid/ready handshake.
//   It arbitrates among the requesting input channels and forwards one word per cycle
//   into a single output register. Arbitration is fixed-priority or round-robin (MODE).
//   It is the multi-channel, pipelined successor to the combinational 2:1 mux slices,
//   used wherever several producers share one consumer.
// PARAMETERS
//   SIZE  2  data width per channel, in bits (>=1)
//   NCH   4  number of input channels (>=2)
//   MODE  1  0 = fixed priority (ch0 highest), 1 = round-robin
//   CW    $clog2(NCH)  channel-index width (derived; do not override)
// PORTS
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-high reset
//   in_valid   in   NCH       per-channel request
//   in_data    in   NCH*SIZE  channel i occupies bits [i*SIZE +: SIZE]
//   in_ready   out  NCH       per-channel accept; at most one bit high
//   out_valid  out  1         output register holds a valid word
//   out_data   out  SIZE      registered data
//   out_ch     out  CW        source channel of out_data
//   out_ready  in   1         consumer accept
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, ptr=0.
//     in_ready is all-zero while reset is high.
//   - load  = ~out_valid | out_ready   (output register free or draining this cycle).
//   - grant = one-hot pick among in_valid; combinational.
//       MODE 0: lowest index wins.
//       MODE 1: first requester at or after ptr, searching upward and wrapping NCH-1 -> 0.
//   - in_ready = grant & {NCH{load}}. A transfer on channel i occurs when
//     in_valid[i] & in_ready[i].
//   - in_ready must not depend combinationally on in_data. It depends on in_valid,
//     ptr, out_valid and out_ready only.
//   - Each rising edge with load=1:
//       out_valid <= |in_valid;
//       if a transfer occurs: out_data <= granted data; out_ch <= granted index.
//   - Each rising edge with load=0: all output registers hold.
//       out_data and out_ch must stay stable while out_valid=1 and out_ready=0.
//   - Latency: 1 cycle, input transfer to out_valid. Full throughput is 1 word/cycle
//     when out_ready stays high.
//   - Round-robin pointer (MODE 1):
//       on a transfer from channel g, ptr <= (g==NCH-1) ? 0 : g+1;
//       with no transfer, ptr holds.
//     The pointer is the only arbitration state. MODE 0 ignores ptr.
//   - If no channel requests while load=1, out_valid falls to 0. out_data and out_ch
//     hold their last values.
//   - Simultaneous drain and refill (out_valid=1, out_ready=1, a requester present):
//     the new word loads in the same edge with no bubble.
//   - Fairness (MODE 1): a continuously requesting channel is served within NCH
//     transfers.
//   - Reset asserted mid-transfer: a pending output word is discarded and ptr returns
//     to 0. No transfer is counted on that edge.
//   - Non-power-of-two NCH: ptr wraps at NCH-1, never reaches NCH, and out_ch is
//     always < NCH.
// TESTING
//   1 Reset: hold reset with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0,
//     in_ready=0; after release, first transfer is ch0.
//   2 MODE 0, in_valid=4'b1010, out_ready=1 -> ch1 granted every cycle; out_ch=1 from
//     the 2nd cycle on; ch3 is never served.
//   3 MODE 1, NCH=4, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1
//     with out_valid continuously 1.
//   4 Backpressure: out_valid=1 with out_data=2'b10, out_ready=0 for 3 cycles ->
//     out_data/out_ch frozen, in_ready=0; out_ready=1 -> next word loads in the same edge.
//   5 Wrap and sparse: MODE 1, NCH=3, ptr=2, in_valid=3'b001 -> ch0 granted, ptr
//     becomes 1; then in_valid=3'b100 -> ch2 granted, ptr wraps to 0.
//   6 Reset mid-stream during test 3 after out_ch=2 -> out_valid=0 immediately
//     (async); after release, next grant is ch0.

Source files
------------

// File: rtl/y_rr_mux_reg.sv
// y_rr_mux_reg: NCH-channel registered mux with valid/ready handshake and
// fixed-priority (MODE 0) or round-robin (MODE 1) arbitration.
module y_rr_mux_reg #(
    parameter int SIZE = 2,
    parameter int NCH  = 4,
    parameter int MODE = 1,
    parameter int CW   = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*SIZE-1:0] in_data,
    output logic [NCH-1:0]      in_ready,
    output logic                out_valid,
    output logic [SIZE-1:0]     out_data,
    output logic [CW-1:0]       out_ch,
    input  logic                out_ready
);
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   gidx;
    logic [SIZE-1:0] gdata;
    logic            found;
    logic            load;

    // First pass covers ptr..NCH-1, second pass wraps around from 0.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < NCH; i++)
            if (!found && in_valid[i] && (MODE == 0 || i >= int'(ptr))) begin
                found = 1'b1;
                gidx  = CW'(i);
                gdata = in_data[i*SIZE +: SIZE];
            end
        for (int i = 0; i < NCH; i++)
            if (!found && in_valid[i]) begin
                found = 1'b1;
                gidx  = CW'(i);
                gdata = in_data[i*SIZE +: SIZE];
            end
    end

    assign load     = ~out_valid | out_ready;
    assign in_ready = (found & load & ~reset) ? (NCH'(1) << gidx) : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= gdata;
                out_ch   <= gidx;
                ptr      <= (gidx == CW'(NCH-1)) ? '0 : gidx + 1'b1;
            end
        end
endmodule

// File: tb/tb_y_rr_mux_reg.sv
// tb_y_rr_mux_reg: three instances (fixed NCH=4, round-robin NCH=4, round-robin NCH=3)
// checked every cycle against a modulo-arithmetic reference model.
module tb_y_rr_mux_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] iv[3];
    logic [7:0] id[3];
    logic       ordy[3];
    logic [3:0] ir0, ir1;
    logic [2:0] ir2;
    logic       ov0, ov1, ov2;
    logic [1:0] od0, od1, od2, oc0, oc1, oc2;

    y_rr_mux_reg #(.SIZE(2), .NCH(4), .MODE(0)) u0 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ch(oc0), .out_ready(ordy[0]));
    y_rr_mux_reg #(.SIZE(2), .NCH(4), .MODE(1)) u1 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ch(oc1), .out_ready(ordy[1]));
    y_rr_mux_reg #(.SIZE(2), .NCH(3), .MODE(1)) u2 (
        .clk(clk), .reset(rst), .in_valid(iv[2][2:0]), .in_data(id[2][5:0]), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ch(oc2), .out_ready(ordy[2]));

    logic       avl[3];
    logic [1:0] adt[3], ach[3];
    logic [3:0] ard[3];
    always_comb begin
        avl[0] = ov0; avl[1] = ov1; avl[2] = ov2;
        adt[0] = od0; adt[1] = od1; adt[2] = od2;
        ach[0] = oc0; ach[1] = oc1; ach[2] = oc2;
        ard[0] = ir0; ard[1] = ir1; ard[2] = {1'b0, ir2};
    end

    int n_chk = 0;
    int n_fail = 0;
    int nch[3] = '{4, 4, 3};
    int mode[3] = '{0, 1, 1};
    bit mv[3];
    int md[3], mc[3], mp[3];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pick(input int i);
        for (int k = 0; k < nch[i]; k++) begin
            int c = mode[i] != 0 ? (mp[i] + k) % nch[i] : k;
            if (iv[i][c]) return c;
        end
        return -1;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; md[i] = 0; mc[i] = 0; mp[i] = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        if (rst) mreset();
        for (int i = 0; i < 3; i++) begin
            int g = pick(i);
            bit ld = !mv[i] || ordy[i];
            chk($sformatf("out_valid%0d", i), avl[i], mv[i]);
            chk($sformatf("out_data%0d", i), adt[i], md[i]);
            chk($sformatf("out_ch%0d", i), ach[i], mc[i]);
            chk($sformatf("in_ready%0d", i), ard[i], (rst || !ld || g < 0) ? 0 : 1 << g);
            if (!rst && ld) begin
                mv[i] = g >= 0;
                if (g >= 0) begin
                    md[i] = (id[i] >> (2 * g)) & 3;
                    mc[i] = g;
                    mp[i] = (g + 1) % nch[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 4'hf;
            id[i] = 8'($urandom);
            ordy[i] = 1'b1;
        end
        mreset();
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        chk("t1_first_ch", ach[1], 0);
        chk("t1_first_valid", avl[1], 1);
        for (int k = 1; k < 6; k++) begin
            cycle();
            chk($sformatf("t3_seq%0d", k), ach[1], k % 4);
            chk($sformatf("t3_valid%0d", k), avl[1], 1);
        end
        iv[0] = 4'b1010;
        repeat (4) cycle();
        chk("t2_ch", ach[0], 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("t6_pre", ach[1], 2);
        #2 rst = 1'b1;
        #1 chk("t6_async", avl[1], 0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("t6_after", ach[1], 0);
        iv[0] = 4'b0001;
        id[0] = 8'h02;
        cycle();
        chk("t4_load", adt[0], 2);
        ordy[0] = 1'b0;
        iv[0] = 4'b0110;
        id[0] = 8'h04;
        repeat (3) begin
            cycle();
            chk("t4_hold_d", adt[0], 2);
            chk("t4_hold_c", ach[0], 0);
            chk("t4_hold_ir", ard[0], 0);
        end
        ordy[0] = 1'b1;
        cycle();
        chk("t4_next_d", adt[0], 1);
        chk("t4_next_c", ach[0], 1);
        chk("t4_next_v", avl[0], 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        iv[2] = 4'b0010;
        cycle();
        iv[2] = 4'b0001;
        #1 chk("t5_g0", ard[2], 1);
        cycle();
        chk("t5_ch0", ach[2], 0);
        iv[2] = 4'b0100;
        #1 chk("t5_g2", ard[2], 4);
        cycle();
        chk("t5_ch2", ach[2], 2);
        iv[2] = 4'b0111;
        #1 chk("t5_wrap", ard[2], 1);
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                iv[i] = (i == 2) ? 4'($urandom % 8) : 4'($urandom);
                id[i] = 8'($urandom);
                ordy[i] = ($urandom % 4) != 0;
            end
            rst = ($urandom % 50) == 0;
            cycle();
        end
        rst = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
